// File: rtl/fasm_rdstream_pkg.sv
// ---------------------------------------------------------------------------
// | fasm_rdstream_pkg                                                        |
// | Shared FASM read-stream defaults and FSM state encodings.                |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

package fasm_rdstream_pkg;

  localparam int c_aw_default = 8;
  localparam int c_dw_default = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fasm_skidbuf.sv
// ---------------------------------------------------------------------------
// | fasm_skidbuf                                                             |
// | Two-entry FIFO; the head is a register, so push never reaches the output.|
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module fasm_skidbuf
  import fasm_rdstream_pkg::*;
#(
  parameter int DW = c_dw_default
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] pdat_i,
  input  logic          pop_i,
  output logic [DW-1:0] hdat_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic [1:0]    r_occ;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = pop_i && (r_occ != 2'd0);
  assign w_push = push_i && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_d0 <= pdat_i;
          else               r_d1 <= pdat_i;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (r_occ == 2'd1) begin
            r_d0 <= pdat_i;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= pdat_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign hdat_o = r_d0;
  assign occ_o  = r_occ;

endmodule

`default_nettype wire

// File: rtl/fasm_rdstream.sv
// ---------------------------------------------------------------------------
// | fasm_rdstream                                                            |
// | Streams a (start, length) range out of the FASM synchronous read port.   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module fasm_rdstream
  import fasm_rdstream_pkg::*;
#(
  parameter int AW = c_aw_default,
  parameter int DW = c_dw_default
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] cadr_i,
  input  logic [AW-1:0] clen_i,
  input  logic          cstb_i,
  output logic          busy_o,
  output logic [AW-1:0] madr_o,
  output logic          mstb_o,
  input  logic [DW-1:0] mdat_i,
  output logic [DW-1:0] sdat_o,
  output logic          svld_o,
  output logic          slst_o,
  input  logic          srdy_i
);

  localparam logic [AW-1:0] c_one = AW'(1);

  rd_state_t     r_state;
  logic [AW-1:0] r_adr;
  logic [AW-1:0] r_icnt;
  logic [AW-1:0] r_bcnt;
  logic          r_infl;
  logic          r_busy;

  logic [1:0]    w_occ;
  logic [DW-1:0] w_hdat;
  logic          w_svld;
  logic          w_pop;
  logic          w_last;
  logic          w_issue;

  assign w_svld = (w_occ != 2'd0);
  assign w_pop  = w_svld && srdy_i;
  assign w_last = (r_bcnt == '0);

  // Buffered plus in-flight words never exceed the two FIFO slots.
  assign w_issue = rst_i && (r_state == ST_RUN) &&
                   (((w_occ + {1'b0, r_infl}) < 2'd2) || w_pop);

  fasm_skidbuf #(
    .DW (DW)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (r_infl),
    .pdat_i (mdat_i),
    .pop_i  (w_pop),
    .hdat_o (w_hdat),
    .occ_o  (w_occ)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_icnt  <= '0;
      r_bcnt  <= '0;
      r_infl  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_adr  <= r_adr + c_one;
        r_icnt <= r_icnt - c_one;
      end
      if (w_pop && !w_last) r_bcnt <= r_bcnt - c_one;

      case (r_state)
        ST_IDLE: begin
          if (cstb_i) begin
            r_adr   <= cadr_i;
            r_icnt  <= clen_i;
            r_bcnt  <= clen_i;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue && (r_icnt == '0)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_pop && w_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign madr_o = r_adr;
  assign mstb_o = w_issue;
  assign sdat_o = w_hdat;
  assign svld_o = w_svld;
  assign slst_o = w_svld && w_last;

endmodule

`default_nettype wire

// File: doc/fasm_rdstream.md
# fasm_rdstream

Single-clock read-streaming engine for the FASM two-port memory's synchronous read port: it accepts a (start address, length) command, issues the address and strobe sequence to the memory's registered-address read port, absorbs the one-cycle read latency, and presents the words as a valid/ready stream with back-pressure. It sits between a FASM memory block, fed by a producer on the write port, and any stream consumer such as a DMA or serialiser. It is the reader counterpart to the memory's write side.

## Interface
- AW, 8: memory address width; 2^AW words.
- DW, 32: data word width in bits.

- clk_i  in  1  clock; everything is on its rising edge.
- rst_i  in  1  reset; synchronous, active-low (0 = reset).
- cadr_i  in  AW  command start address.
- clen_i  in  AW  command length minus one (0 = 1 word; all-ones = 2^AW words).
- cstb_i  in  1  command strobe; accepted only when busy_o=0.
- busy_o  out  1  command in progress.
- madr_o  out  AW  memory read address.
- mstb_o  out  1  memory read strobe (memory latches madr_o on this edge).
- mdat_i  in  DW  memory read data; valid in the cycle after mstb_o.
- sdat_o  out  DW  stream data.
- svld_o  out  1  stream valid.
- slst_o  out  1  marks the last word of the command; qualified by svld_o.
- srdy_i  in  1  stream ready; a beat transfers when svld_o&srdy_i.

## Operation
- Reset values: busy_o=0, mstb_o=0, madr_o=0, svld_o=0, slst_o=0, sdat_o=0. Internal counters and buffer are cleared.
- States:
  - IDLE: on cstb_i=1, latch cadr_i into the address counter and clen_i into the issue and beat counters, then go to RUN.
  - RUN: issue reads.
  - DRAIN: entered once the last read has issued; return to IDLE when the last beat (slst_o) transfers.
- busy_o=1 in RUN and DRAIN.
- cstb_i while busy_o=1 is ignored; no queueing.
- Issue rule: assert mstb_o when all of the following hold:
  - state is RUN;
  - buffered + in-flight < 2, or a beat transfers this cycle.
- Each issue post-increments the address modulo 2^AW. Wrap from 2^AW-1 to 0 is legal and silent.
- The word returned on mdat_i is written into a 2-entry FIFO in the cycle after its mstb_o. The FIFO head drives sdat_o and svld_o.
- The beat counter decrements on each transfer. slst_o=1 exactly when the head is the final word.
- Stream rules:
  - sdat_o, svld_o and slst_o are held stable while svld_o=1 and srdy_i=0.
  - svld_o never drops without a transfer.
- Push and pop in the same cycle is legal, and the occupancy count is unchanged.
- The FIFO must never overflow. The issue rule guarantees this; the bench asserts it.
- Reset asserted mid-command: abort immediately. All state is flushed and returns to reset values the next cycle, and no further mstb_o is issued.

## Timing
- Command accepted at edge of cycle 0 → first mstb_o in cycle 1 → mdat_i in cycle 2 → first svld_o in cycle 3.
- Throughput: 1 word/cycle sustained with srdy_i=1.
- An N-word command with srdy_i held at 1:
  - last beat transfers in cycle N+2;
  - busy_o=0 in cycle N+3;
  - a new command can be accepted in cycle N+3.
- After srdy_i has been low long enough to fill the FIFO, at most 2 words are buffered and no mstb_o is issued. Streaming resumes the cycle srdy_i rises, with no bubble.
- madr_o is don't-care while mstb_o=0, but is held at its last value.

## Structure
- Shared include holds the state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) alongside the AW/DW defaults used by the FASM library.
- Sub-module fasm_skidbuf is the 2-entry, DW-wide FIFO. It has push/pop/occupancy ports, synchronous active-low reset, and no combinational path from push to the output.
- The top level holds the FSM, the address, issue and beat counters, and the in-flight flag.
- Bench: a behavioural two-port memory model with a registered read address and 1-cycle latency, preloaded with mem[i]=i.

## Test plan
- **Basic:** cadr_i=8'h10, clen_i=3, srdy_i=1 → mstb_o in cycles 1–4 with madr_o 10,11,12,13. Stream words 10..13 in cycles 3–6. slst_o only with 13. busy_o=0 in cycle 7.
- **Wrap:** cadr_i=8'hFE, clen_i=3 → madr_o FE,FF,00,01, and the stream matches that order.
- **Back-pressure:** clen_i=7 with srdy_i=0 for cycles 3–10 → exactly 2 words buffered and mstb_o held low. Output is stable during the stall. After release, all 8 words arrive in order with no gaps.
- **Random srdy_i (50%), clen_i=255 (256 words):** stream equals mem[0..255] in order. No FIFO overflow. One slst_o.
- **Ignored command:** cstb_i pulsed with cadr_i=8'h80 mid-command → the stream is unaffected and no access to 80 occurs.
- **Reset mid-command:** rst_i=0 in cycle 5 of a 16-word command → all outputs at reset values the next cycle. A new command issued after reset completes correctly.
